// File: rtl/adder_tree_scheduler_pkg.sv
// Shared definitions for the adder-tree scheduler: default geometry,
// derived operand/sum widths and the scheduler FSM state type.
// Latency: n/a (package). Backpressure: n/a (package).
package adder_tree_pkg;

  localparam int N_STAGE_DEF = 5;
  localparam int N_REQ_DEF   = 4;
  localparam int N_CHUNK_DEF = 4;

  // Tree input is 2**N_STAGE unsigned 2-bit operands; sum of all of them
  // needs N_STAGE+2 bits.
  localparam int TREE_W = 2 * (2 ** N_STAGE_DEF);
  localparam int SUM_W  = N_STAGE_DEF + 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Index width that stays at least one bit for degenerate counts.
  function automatic int id_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adder_tree_scheduler_if.sv
// Bundle of request, adder-tree and result signals of the scheduler.
// Latency: n/a (wiring). Backpressure: result_valid/result_ready handshake.
// Ports: master = requesters + external tree + result sink, slave = scheduler.
interface adder_tree_scheduler_if
  import adder_tree_pkg::*;
#(
  parameter int N_STAGE = N_STAGE_DEF,
  parameter int N_REQ   = N_REQ_DEF,
  parameter int N_CHUNK = N_CHUNK_DEF
);
  localparam int TREE_BITS = 2 * (2 ** N_STAGE);
  localparam int SUM_BITS  = N_STAGE + 2;
  localparam int ACC_BITS  = SUM_BITS + $clog2(N_CHUNK);
  localparam int ID_BITS   = id_bits(N_REQ);

  logic [N_REQ-1:0]                   req_valid;
  logic [N_REQ*N_CHUNK*TREE_BITS-1:0] req_data;
  logic [N_REQ-1:0]                   req_ready;
  logic [TREE_BITS-1:0]               tree_wx;
  logic [SUM_BITS-1:0]                tree_sum;
  logic                               result_valid;
  logic                               result_ready;
  logic [ACC_BITS-1:0]                result_sum;
  logic [ID_BITS-1:0]                 result_id;
  logic                               busy;

  modport master (
    output req_valid, req_data, tree_sum, result_ready,
    input  req_ready, tree_wx, result_valid, result_sum, result_id, busy
  );

  modport slave (
    input  req_valid, req_data, tree_sum, result_ready,
    output req_ready, tree_wx, result_valid, result_sum, result_id, busy
  );

endinterface

// File: rtl/adder_tree_scheduler_rr_arbiter.sv
// Round-robin pick: first requester with req set at or after last_grant+1.
// Latency: combinational. Backpressure: none; caller decides when to latch.
// Ports: req (valids), last_grant (previous winner) -> grant index, any.
module rr_arbiter
  import adder_tree_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  localparam int ID_BITS = id_bits(N_REQ)
) (
  input  logic [N_REQ-1:0]   req,
  input  logic [ID_BITS-1:0] last_grant,
  output logic [ID_BITS-1:0] grant,
  output logic               any
);

  // Walk offsets from the farthest to the nearest so the closest
  // requester after last_grant is the final (winning) assignment.
  always_comb begin
    grant = '0;
    any   = 1'b0;
    for (int i = N_REQ; i >= 1; i--) begin
      if (req[ID_BITS'((int'(last_grant) + i) % N_REQ)]) begin
        grant = ID_BITS'((int'(last_grant) + i) % N_REQ);
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/adder_tree_scheduler.sv
// Time-shares one external adder tree among N_REQ requesters: streams the
// granted vector chunk by chunk, accumulates the registered tree sums.
// Latency: accept at t -> result_valid at t+N_CHUNK+2. Backpressure: DONE
// holds while result_ready=0; no new grant until the result is taken.
// Ports: clk, rst (async, active-high), bus (slave side of the interface).
module adder_tree_scheduler
  import adder_tree_pkg::*;
#(
  parameter int N_STAGE = N_STAGE_DEF,
  parameter int N_REQ   = N_REQ_DEF,
  parameter int N_CHUNK = N_CHUNK_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  adder_tree_scheduler_if.slave bus
);

  localparam int TREE_BITS = 2 * (2 ** N_STAGE);
  localparam int SUM_BITS  = N_STAGE + 2;
  localparam int ACC_BITS  = SUM_BITS + $clog2(N_CHUNK);
  localparam int ID_BITS   = id_bits(N_REQ);
  localparam int CNT_BITS  = id_bits(N_CHUNK);

  localparam logic [CNT_BITS-1:0] LAST_CHUNK = CNT_BITS'(N_CHUNK - 1);
  localparam logic [ID_BITS-1:0]  LAST_REQ   = ID_BITS'(N_REQ - 1);

  state_t               state, state_nxt;
  logic [CNT_BITS-1:0]  cnt;
  logic [ID_BITS-1:0]   grant_q;
  logic [ID_BITS-1:0]   last_grant;
  logic [ID_BITS-1:0]   arb_grant;
  logic                 arb_any;
  logic [SUM_BITS-1:0]  pipe_reg;
  logic                 pipe_vld;
  logic [ACC_BITS-1:0]  acc;
  logic                 accept;
  logic                 handshake;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req        (bus.req_valid),
    .last_grant (last_grant),
    .grant      (arb_grant),
    .any        (arb_any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt        = state;
    accept           = 1'b0;
    handshake        = 1'b0;
    bus.req_ready    = '0;
    bus.tree_wx      = '0;
    bus.result_valid = 1'b0;
    bus.result_sum   = '0;
    bus.result_id    = '0;
    bus.busy         = (state != IDLE);

    case (state)
      IDLE: begin
        if (arb_any) begin
          accept    = 1'b1;
          state_nxt = FEED;
        end
      end

      FEED: begin
        // Constant-index mux: requester r, chunk c sits at slice r*N_CHUNK+c.
        for (int r = 0; r < N_REQ; r++) begin
          for (int c = 0; c < N_CHUNK; c++) begin
            if (grant_q == ID_BITS'(r) && cnt == CNT_BITS'(c)) begin
              bus.tree_wx = bus.req_data[(r*N_CHUNK + c)*TREE_BITS +: TREE_BITS];
            end
          end
        end
        // Last chunk is on the tree now, so the requester may move on.
        if (cnt == LAST_CHUNK) begin
          bus.req_ready[grant_q] = 1'b1;
          state_nxt              = DRAIN;
        end
      end

      DRAIN: state_nxt = DONE;

      DONE: begin
        bus.result_valid = 1'b1;
        bus.result_sum   = acc;
        bus.result_id    = grant_q;
        if (bus.result_ready) begin
          handshake = 1'b1;
          state_nxt = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  // Tree output is registered one cycle before it is accumulated, so the
  // accumulator trails the chunk counter by one cycle and DRAIN adds the
  // final chunk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      grant_q    <= '0;
      last_grant <= LAST_REQ;
      pipe_reg   <= '0;
      pipe_vld   <= 1'b0;
      acc        <= '0;
    end else begin
      if (pipe_vld) acc <= acc + ACC_BITS'(pipe_reg);
      case (state)
        IDLE: begin
          if (accept) begin
            grant_q  <= arb_grant;
            cnt      <= '0;
            acc      <= '0;
            pipe_vld <= 1'b0;
          end
        end
        FEED: begin
          pipe_reg <= bus.tree_sum;
          pipe_vld <= 1'b1;
          cnt      <= (cnt == LAST_CHUNK) ? '0 : cnt + CNT_BITS'(1);
        end
        DRAIN: pipe_vld <= 1'b0;
        DONE: begin
          if (handshake) last_grant <= grant_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_tree_scheduler.sv
// Self-checking bench for adder_tree_scheduler: a table of whole
// transactions plus directed sequences for backpressure, round-robin
// streaming, mid-transaction reset and early valid drop.
module tb_adder_tree_scheduler;

  localparam int N_STAGE   = 5;
  localparam int N_REQ     = 4;
  localparam int N_CHUNK   = 4;
  localparam int TREE_BITS = 64;
  localparam int DATA_BITS = N_REQ * N_CHUNK * TREE_BITS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

  adder_tree_scheduler_if #(.N_STAGE(N_STAGE), .N_REQ(N_REQ), .N_CHUNK(N_CHUNK)) bus ();

  adder_tree_scheduler #(.N_STAGE(N_STAGE), .N_REQ(N_REQ), .N_CHUNK(N_CHUNK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // External adder tree: sum of the 32 two-bit operands.
  function automatic logic [6:0] tree_add(input logic [63:0] wx);
    int s = 0;
    for (int k = 0; k < 32; k++) s += int'(wx[2*k +: 2]);
    return 7'(s);
  endfunction

  assign bus.tree_sum = tree_add(bus.tree_wx);

  // ops[8r+2c +: 2] is the value of every operand in requester r, chunk c.
  function automatic logic [DATA_BITS-1:0] build(input logic [31:0] ops);
    logic [DATA_BITS-1:0] d = '0;
    for (int r = 0; r < N_REQ; r++)
      for (int c = 0; c < N_CHUNK; c++)
        for (int k = 0; k < 32; k++)
          d[((r*N_CHUNK + c)*32 + k)*2 +: 2] = ops[8*r + 2*c +: 2];
    return d;
  endfunction

  // Target requester gets ops (chunk0 in LSBs); all others hold operand 2.
  function automatic logic [31:0] one_tgt(input int tgt, input logic [7:0] ops);
    logic [31:0] o = {4{8'hAA}};
    o[8*tgt +: 8] = ops;
    return o;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic handshake();
    bus.result_ready = 1'b1;
    step();
    bus.result_ready = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req_ready"},    bus.req_ready, 0);
    check({tag, "_tree_wx"},      bus.tree_wx, 0);
    check({tag, "_busy"},         bus.busy, 0);
    check({tag, "_result_valid"}, bus.result_valid, 0);
    check({tag, "_result_sum"},   bus.result_sum, 0);
    check({tag, "_result_id"},    bus.result_id, 0);
  endtask

  // Steps until result_valid (bounded); records first req_ready pulse.
  // drop_at>0 clears every req_valid after that many cycles.
  task automatic wait_result(input int drop_at, output int lat,
                             output int rdy_lat, output logic [3:0] rdy_vec);
    lat = -1; rdy_lat = -1; rdy_vec = '0;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (k == drop_at) bus.req_valid = '0;
      if (bus.req_ready != 0 && rdy_lat < 0) begin
        rdy_lat = k;
        rdy_vec = bus.req_ready;
      end
      if (bus.result_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  typedef struct {
    logic [3:0] valid;
    int         tgt;
    logic [7:0] ops;      // {c3,c2,c1,c0}
    int         exp_id;
    int         exp_sum;
  } vec_t;

  vec_t vecs[7];
  int   rr_exp[5] = '{0, 1, 2, 3, 0};

  initial begin
    int lat, rlat, found, prev;
    logic [3:0] rvec;

    // last_grant starts at 3, so the table's grants follow from that.
    vecs[0] = '{4'b0001, 0, {2'd3, 2'd3, 2'd3, 2'd3}, 0, 384};
    vecs[1] = '{4'b0100, 2, {2'd3, 2'd2, 2'd1, 2'd0}, 2, 192};
    vecs[2] = '{4'b0101, 0, {2'd1, 2'd0, 2'd0, 2'd2}, 0, 96};
    vecs[3] = '{4'b1111, 1, {2'd0, 2'd3, 2'd0, 2'd3}, 1, 192};
    vecs[4] = '{4'b1001, 3, {2'd0, 2'd0, 2'd0, 2'd0}, 3, 0};
    vecs[5] = '{4'b1000, 3, {2'd0, 2'd3, 2'd2, 2'd1}, 3, 192};
    vecs[6] = '{4'b0110, 1, {2'd2, 2'd3, 2'd3, 2'd3}, 1, 352};

    bus.req_valid    = '0;
    bus.req_data     = '0;
    bus.result_ready = 1'b0;

    // Reset state
    step(); step();
    check_all_zero("reset");
    rst = 1'b0;
    step();
    check_all_zero("post_reset");

    // Table-driven transactions
    for (int i = 0; i < 7; i++) begin
      check($sformatf("vec%0d_idle_tree_wx", i), bus.tree_wx, 0);
      bus.req_data  = build(one_tgt(vecs[i].tgt, vecs[i].ops));
      bus.req_valid = vecs[i].valid;
      wait_result(4, lat, rlat, rvec);
      check($sformatf("vec%0d_ready_lat", i), rlat, 4);
      check($sformatf("vec%0d_ready_vec", i), rvec, 64'(1) << vecs[i].exp_id);
      check($sformatf("vec%0d_result_lat", i), lat, 6);
      check($sformatf("vec%0d_result_id", i), bus.result_id, vecs[i].exp_id);
      check($sformatf("vec%0d_result_sum", i), bus.result_sum, vecs[i].exp_sum);
      check($sformatf("vec%0d_done_tree_wx", i), bus.tree_wx, 0);
      handshake();
      check($sformatf("vec%0d_idle_busy", i), bus.busy, 0);
    end

    // Backpressure: last_grant=1, requesters 0 and 1 hold valid throughout
    bus.req_data  = build(one_tgt(0, 8'h55));
    bus.req_valid = 4'b0011;
    wait_result(0, lat, rlat, rvec);
    check("bp_lat", lat, 6);
    check("bp_id", bus.result_id, 0);
    check("bp_sum", bus.result_sum, 128);
    for (int k = 0; k < 10; k++) begin
      step();
      check($sformatf("bp_hold%0d_valid", k), bus.result_valid, 1);
      check($sformatf("bp_hold%0d_id", k), bus.result_id, 0);
      check($sformatf("bp_hold%0d_sum", k), bus.result_sum, 128);
      check($sformatf("bp_hold%0d_tree_wx", k), bus.tree_wx, 0);
      check($sformatf("bp_hold%0d_req_ready", k), bus.req_ready, 0);
    end
    handshake();
    wait_result(0, lat, rlat, rvec);
    check("bp_next_lat", lat, 6);
    check("bp_next_id", bus.result_id, 1);
    check("bp_next_sum", bus.result_sum, 256);
    handshake();
    bus.req_valid = '0;

    // Round-robin streaming with all requesters valid
    rst = 1'b1;
    step();
    check_all_zero("rr_reset");
    rst = 1'b0;
    step();
    bus.req_data     = build({8'hFF, 8'hAA, 8'h55, 8'h00});
    bus.req_valid    = 4'hF;
    bus.result_ready = 1'b1;
    found = 0;
    prev  = 0;
    for (int k = 1; k <= 45 && found < 5; k++) begin
      step();
      if (bus.result_valid) begin
        check($sformatf("rr%0d_id", found), bus.result_id, rr_exp[found]);
        check($sformatf("rr%0d_sum", found), bus.result_sum, 128 * rr_exp[found]);
        if (found > 0) check($sformatf("rr%0d_period", found), k - prev, 7);
        else           check("rr0_lat", k, 6);
        prev = k;
        found++;
        if (found == 5) bus.req_valid = '0;
      end
    end
    check("rr_count", found, 5);
    step();
    bus.result_ready = 1'b0;

    // Reset during FEED chunk 2 (last_grant is 0 here, so requester 2 wins)
    bus.req_data  = build(one_tgt(2, {2'd3, 2'd2, 2'd1, 2'd0}));
    bus.req_valid = 4'b0100;
    step(); step(); step();
    check("rst_chunk2_wx", bus.tree_wx, {32{2'b10}});
    check("rst_busy_before", bus.busy, 1);
    rst = 1'b1;
    step();
    check_all_zero("midrst");
    rst = 1'b0;
    bus.req_valid = 4'b0101;
    wait_result(4, lat, rlat, rvec);
    check("midrst_ready_lat", rlat, 4);
    check("midrst_ready_vec", rvec, 4'b0001);
    check("midrst_lat", lat, 6);
    check("midrst_id", bus.result_id, 0);
    check("midrst_sum", bus.result_sum, 256);
    handshake();

    // Requester 1 drops req_valid two cycles into FEED
    bus.req_data  = build(one_tgt(1, {2'd0, 2'd1, 2'd3, 2'd2}));
    bus.req_valid = 4'b0010;
    wait_result(2, lat, rlat, rvec);
    check("drop_ready_lat", rlat, 4);
    check("drop_ready_vec", rvec, 4'b0010);
    check("drop_lat", lat, 6);
    check("drop_id", bus.result_id, 1);
    check("drop_sum", bus.result_sum, 192);
    handshake();
    check("drop_idle_busy", bus.busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d failures=%0d", n_chk, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
